axi_lite_uart: RTL

AXI4-Lite slave UART peripheral inside picorv32_soc_top, on the same interconnect as the scratchpad.
- Drives the SoC serial output o_uart_rx, which feeds the host's RX pin.
- Samples the SoC serial input i_uart_tx, which comes from the host's TX pin.
- Format is fixed 8N1, LSB first. TX is buffered in a FIFO; RX holds a single byte.
- Firmware uses it for console output and for end-of-test messages before trapping.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/axi_lite_uart.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the AXI4-Lite UART: register offsets, STATUS bit positions, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    // Register select is the word index addr[3:2].
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_RXDATA = 2'd1;
    localparam logic [1:0] UART_STATUS = 2'd2;
    localparam logic [1:0] UART_CLEAR  = 2'd3;

    // STATUS register bit positions.
    localparam int STAT_TX_FULL      = 0;
    localparam int STAT_TX_EMPTY     = 1;
    localparam int STAT_RX_VALID     = 2;
    localparam int STAT_RX_OVERRUN   = 3;
    localparam int STAT_RX_FRAME_ERR = 4;
    localparam int STAT_TX_DROP      = 5;

    // Frame position, used by both the TX and RX state machines.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head (pop_dat is valid whenever !empty).
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: pushes to a full FIFO are refused unless a pop happens in the same cycle.
// Ports: clk/rst_n (sync active-low); push_vld/push_dat write side; pop_rdy/pop_dat read side;
//        full/empty occupancy flags.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_vld,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop_rdy,
    output logic [DATA_W-1:0] pop_dat,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    logic do_push;
    logic do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign do_push = push_vld && (!full || pop_rdy);
    assign do_pop  = pop_rdy && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_uart.sv
// AXI4-Lite slave UART, fixed 8N1 LSB-first, buffered TX FIFO and single-byte RX holding register.
// Latency: ready pulses one cycle after valid, B/R responses one cycle after the handshake; TX line
//          leaves idle two cycles after the push is accepted.
// Backpressure: one write and one read outstanding; B/R held until bready/rready; TX pushes to a full FIFO are dropped.
// Ports: i_clk/i_rst_n (sync active-low); AW/W/B and AR/R AXI4-Lite channels;
//        o_uart_rx serial output (idle high); i_uart_tx serial input (asynchronous).
module axi_lite_uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 868,
    parameter int TX_FIFO_DEPTH = 8,
    parameter int ADDR_W        = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    output logic [1:0]        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic              i_arvalid,
    output logic              o_arready,
    output logic [31:0]       o_rdata,
    output logic [1:0]        o_rresp,
    output logic              o_rvalid,
    input  logic              i_rready,
    output logic              o_uart_rx,
    input  logic              i_uart_tx
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    // ---------------- AXI write channel ----------------
    logic aw_rdy;
    logic wr_fire;
    logic tx_push;
    logic clr_wr;

    assign o_awready = aw_rdy;
    assign o_wready  = aw_rdy;
    assign o_bresp   = 2'b00;
    assign wr_fire   = aw_rdy && i_awvalid && i_wvalid;
    assign tx_push   = wr_fire && (i_awaddr[3:2] == UART_TXDATA) && i_wstrb[0];
    assign clr_wr    = wr_fire && (i_awaddr[3:2] == UART_CLEAR);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            aw_rdy   <= 1'b0;
            o_bvalid <= 1'b0;
        end else begin
            // !aw_rdy keeps the ready a single-cycle pulse.
            aw_rdy <= i_awvalid && i_wvalid && !o_bvalid && !aw_rdy;
            if (wr_fire) begin
                o_bvalid <= 1'b1;
            end else if (i_bready) begin
                o_bvalid <= 1'b0;
            end
        end
    end

    // ---------------- TX FIFO ----------------
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dat;
    logic       tx_pop;

    sync_fifo #(
        .DATA_W (8),
        .DEPTH  (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push_vld (tx_push),
        .push_dat (i_wdata[7:0]),
        .pop_rdy  (tx_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ---------------- TX FSM ----------------
    uart_state_e tx_state, tx_state_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt;
    logic [2:0]  tx_idx, tx_idx_nxt;
    logic [7:0]  tx_shift, tx_shift_nxt;
    logic        tx_line;
    logic        tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            o_uart_rx <= 1'b1;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_cnt    <= tx_cnt_nxt;
            tx_idx    <= tx_idx_nxt;
            tx_shift  <= tx_shift_nxt;
            o_uart_rx <= tx_line;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt + 16'd1;
        tx_idx_nxt   = tx_idx;
        tx_shift_nxt = tx_shift;
        tx_pop       = 1'b0;
        tx_line      = 1'b1;
        case (tx_state)
            IDLE: begin
                tx_cnt_nxt = '0;
                if (!fifo_empty) begin
                    tx_pop       = 1'b1;
                    tx_shift_nxt = fifo_dat;
                    tx_state_nxt = START;
                end
            end
            START: begin
                tx_line = 1'b0;
                if (tx_bit_end) begin
                    tx_cnt_nxt   = '0;
                    tx_idx_nxt   = '0;
                    tx_state_nxt = DATA;
                end
            end
            DATA: begin
                tx_line = tx_shift[0];
                if (tx_bit_end) begin
                    tx_cnt_nxt   = '0;
                    tx_shift_nxt = {1'b0, tx_shift[7:1]};
                    tx_idx_nxt   = tx_idx + 3'd1;
                    if (tx_idx == 3'd7) begin
                        tx_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                tx_line = 1'b1;
                if (tx_bit_end) begin
                    tx_cnt_nxt = '0;
                    // Chain straight into the next start bit so queued bytes go out gap-free.
                    if (!fifo_empty) begin
                        tx_pop       = 1'b1;
                        tx_shift_nxt = fifo_dat;
                        tx_state_nxt = START;
                    end else begin
                        tx_state_nxt = IDLE;
                    end
                end
            end
            default: tx_state_nxt = IDLE;
        endcase
    end

    // ---------------- RX synchroniser + FSM ----------------
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_fall;
    uart_state_e rx_state, rx_state_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt;
    logic [2:0]  rx_idx, rx_idx_nxt;
    logic [7:0]  rx_shift, rx_shift_nxt;
    logic        rx_wait_high, rx_wait_high_nxt;
    logic        rx_done;
    logic        rx_ferr;

    assign rx_fall = rx_prev && !rx_s2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_shift     <= '0;
            rx_wait_high <= 1'b0;
        end else begin
            rx_s1        <= i_uart_tx;
            rx_s2        <= rx_s1;
            rx_prev      <= rx_s2;
            rx_state     <= rx_state_nxt;
            rx_cnt       <= rx_cnt_nxt;
            rx_idx       <= rx_idx_nxt;
            rx_shift     <= rx_shift_nxt;
            rx_wait_high <= rx_wait_high_nxt;
        end
    end

    always_comb begin
        rx_state_nxt     = rx_state;
        rx_cnt_nxt       = rx_cnt + 16'd1;
        rx_idx_nxt       = rx_idx;
        rx_shift_nxt     = rx_shift;
        rx_wait_high_nxt = rx_wait_high;
        rx_done          = 1'b0;
        rx_ferr          = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_nxt = '0;
                // After a framing error the line may still be low; re-arm only once it idles high.
                if (rx_wait_high) begin
                    if (rx_s2) begin
                        rx_wait_high_nxt = 1'b0;
                    end
                end else if (rx_fall) begin
                    rx_state_nxt = START;
                end
            end
            START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt = '0;
                    if (rx_s2) begin
                        rx_state_nxt = IDLE;   // glitch, not a start bit
                    end else begin
                        rx_idx_nxt   = '0;
                        rx_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_s2, rx_shift[7:1]};
                    rx_idx_nxt   = rx_idx + 3'd1;
                    if (rx_idx == 3'd7) begin
                        rx_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = IDLE;
                    if (rx_s2) begin
                        rx_done = 1'b1;
                    end else begin
                        rx_ferr          = 1'b1;
                        rx_wait_high_nxt = 1'b1;
                    end
                end
            end
            default: rx_state_nxt = IDLE;
        endcase
    end

    // ---------------- AXI read channel + flags ----------------
    logic        ar_rdy;
    logic        rd_fire;
    logic        rx_clr;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_overrun;
    logic        rx_frame_err;
    logic        tx_drop;
    logic        tx_drop_set;
    logic [31:0] status;
    logic [31:0] rd_mux;

    assign o_arready   = ar_rdy;
    assign o_rresp     = 2'b00;
    assign rd_fire     = ar_rdy && i_arvalid;
    assign rx_clr      = rd_fire && (i_araddr[3:2] == UART_RXDATA);
    assign tx_drop_set = tx_push && fifo_full && !tx_pop;

    always_comb begin
        status                    = '0;
        status[STAT_TX_FULL]      = fifo_full;
        status[STAT_TX_EMPTY]     = fifo_empty && (tx_state == IDLE);
        status[STAT_RX_VALID]     = rx_valid;
        status[STAT_RX_OVERRUN]   = rx_overrun;
        status[STAT_RX_FRAME_ERR] = rx_frame_err;
        status[STAT_TX_DROP]      = tx_drop;
    end

    always_comb begin
        rd_mux = '0;
        case (i_araddr[3:2])
            UART_RXDATA: rd_mux = {23'b0, rx_valid, rx_byte};
            UART_STATUS: rd_mux = status;
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ar_rdy       <= 1'b0;
            o_rvalid     <= 1'b0;
            o_rdata      <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            tx_drop      <= 1'b0;
        end else begin
            ar_rdy <= i_arvalid && !o_rvalid && !ar_rdy;
            // rdata only loads on a handshake, which cannot occur while rvalid is up.
            if (rd_fire) begin
                o_rvalid <= 1'b1;
                o_rdata  <= rd_mux;
            end else if (i_rready) begin
                o_rvalid <= 1'b0;
            end

            // A byte landing on the same cycle as the RXDATA read wins and stays valid.
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_clr) begin
                rx_valid <= 1'b0;
            end

            if (rx_done && rx_valid && !rx_clr) begin
                rx_overrun <= 1'b1;
            end else if (clr_wr && i_wdata[STAT_RX_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end

            if (rx_ferr) begin
                rx_frame_err <= 1'b1;
            end else if (clr_wr && i_wdata[STAT_RX_FRAME_ERR]) begin
                rx_frame_err <= 1'b0;
            end

            if (tx_drop_set) begin
                tx_drop <= 1'b1;
            end else if (clr_wr && i_wdata[STAT_TX_DROP]) begin
                tx_drop <= 1'b0;
            end
        end
    end

    // Address low bits, upper data bytes and upper strobes carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{i_awaddr, i_araddr, i_wdata, i_wstrb};

endmodule
